prog_sequencer: RTL and testbench

Parametrised program sequencer that generates the instruction fetch address for the RISC core. It supports hold, increment, PC-relative branch, absolute jump, subroutine call and return through an internal return-address stack (RAS), plus a pipeline stall input. It sits between the control decoder (which supplies the mode and operands) and the instruction memory address port.

---
 rtl/pseq_pkg.sv | 17 +
 rtl/pseq_ras.sv | 53 +++++
 rtl/prog_sequencer.sv | 105 ++++++++++
 tb/tb_prog_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pseq_pkg.sv
// Shared encodings and default parameters for the program sequencer.
package pseq_pkg;

  localparam int PSEQ_PC_W      = 6;
  localparam int PSEQ_OFS_W     = 6;
  localparam int PSEQ_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    PS_HOLD   = 3'b000,
    PS_INC    = 3'b001,
    PS_BRANCH = 3'b010,
    PS_JUMP   = 3'b011,
    PS_CALL   = 3'b100,
    PS_RET    = 3'b101
  } ps_e;

endpackage

// File: rtl/pseq_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pseq_ras #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] sp_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q, unf_q;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  // sp points at the next free slot; when full that slot is also the oldest
  assign top   = mem_q[sp_q - AW'(1)];

  always_ff @(negedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push) begin
      mem_q[sp_q] <= push_data;
      sp_q        <= sp_q + AW'(1);
      if (full) ovf_q <= 1'b1;
      else      cnt_q <= cnt_q + (AW+1)'(1);
    end else if (pop) begin
      if (empty) begin
        unf_q <= 1'b1;
      end else begin
        sp_q  <= sp_q - AW'(1);
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Instruction fetch address sequencer; falling-edge state, synchronous reset.
// Define PSEQ_RAS_EN to build the return-address stack for CALL/RET.
module prog_sequencer
  import pseq_pkg::*;
#(
  parameter int PC_W      = PSEQ_PC_W,
  parameter int OFS_W     = PSEQ_OFS_W,
  parameter int RAS_DEPTH = PSEQ_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       ps,
  input  logic [PC_W-1:0]  target,
  input  logic [OFS_W-1:0] offset,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_prev,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic             ps_illegal
);

  logic [PC_W-1:0] pc_q, pc_d, prev_q, prev_d, pc_inc, ofs_ext, ret_addr;
  logic            ill_q, ill_d, ret_ok, do_ret;

  assign pc_inc = pc_q + PC_W'(1);
  assign do_ret = !stall && (ps == PS_RET);

  always_comb begin
    ofs_ext = {PC_W{offset[OFS_W-1]}};
    ofs_ext[OFS_W-1:0] = offset;
  end

`ifdef PSEQ_RAS_EN
  logic do_call;
  assign do_call = !stall && (ps == PS_CALL);

  pseq_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_call),
    .pop       (do_ret),
    .push_data (pc_inc),
    .top       (ret_addr),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );
  assign ret_ok = !ras_empty;
`else
  // Without a stack every RET is an underflow and falls through to pc+1.
  logic unf_q;
  always_ff @(negedge clk) begin
    if (reset)       unf_q <= 1'b0;
    else if (do_ret) unf_q <= 1'b1;
  end
  assign ret_addr  = '0;
  assign ret_ok    = 1'b0;
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = unf_q;
`endif

  always_comb begin
    pc_d   = pc_q;
    prev_d = prev_q;
    ill_d  = ill_q;
    if (!stall) begin
      ill_d  = 1'b0;
      prev_d = pc_q;
      case (ps)
        PS_HOLD:          prev_d = prev_q;
        PS_INC:           pc_d   = pc_inc;
        PS_BRANCH:        pc_d   = pc_inc + ofs_ext;
        PS_JUMP, PS_CALL: pc_d   = target;
        PS_RET:           pc_d   = ret_ok ? ret_addr : pc_inc;
        default: begin
          prev_d = prev_q;
          ill_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      prev_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      prev_q <= prev_d;
      ill_q  <= ill_d;
    end
  end

  assign pc         = pc_q;
  assign pc_prev    = prev_q;
  assign ps_illegal = ill_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomised + directed check of prog_sequencer against a queue-based model.
module tb_prog_sequencer;

  localparam int PC_W  = 6;
  localparam int OFS_W = 6;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << PC_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1, stall = 1'b0;
  logic [2:0]       ps = 3'd0;
  logic [PC_W-1:0]  target = '0;
  logic [OFS_W-1:0] offset = '0;
  logic [PC_W-1:0]  pc, pc_prev;
  logic             ras_full, ras_empty, ras_ovf, ras_unf, ps_illegal;

  prog_sequencer #(.PC_W(PC_W), .OFS_W(OFS_W), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ps(ps), .target(target),
    .offset(offset), .pc(pc), .pc_prev(pc_prev), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .ps_illegal(ps_illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit mvalid = 0;
  int m_pc, m_prev, m_ovf, m_unf, m_ill;
  int stk[$];

`ifdef PSEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model written from the sequencing rules: plain ints plus a bounded queue.
  task automatic model(input bit r, input bit s, input int p, input int t, input int o);
    int sx, old;
    if (r) begin
      m_pc = 0; m_prev = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
      stk.delete();
      return;
    end
    if (s) return;
    old = m_pc;
    m_ill = (p >= 6);
    sx = (o >= (1 << (OFS_W-1))) ? o - (1 << OFS_W) : o;
    case (p)
      1: m_pc = (old + 1) & MASK;
      2: m_pc = (old + 1 + sx) & MASK;
      3: m_pc = t;
      4: begin
        if (RAS) begin
          if (stk.size() == DEPTH) begin
            void'(stk.pop_front());
            m_ovf = 1;
          end
          stk.push_back((old + 1) & MASK);
        end
        m_pc = t;
      end
      5: begin
        if (RAS && stk.size() > 0) m_pc = stk.pop_back();
        else begin
          m_pc = (old + 1) & MASK;
          m_unf = 1;
        end
      end
      default: ;
    endcase
    if (p >= 1 && p <= 5) m_prev = old;
  endtask

  task automatic step(input bit r, input bit s, input int p, input int t = 0, input int o = 0);
    @(posedge clk);
    reset = r; stall = s; ps = 3'(p); target = PC_W'(t); offset = OFS_W'(o);
    @(negedge clk);
    #1;
    model(r, s, p, t, o);
    mvalid = 1;
  endtask

  // Every cycle, outputs are compared to the model mid-cycle.
  always @(posedge clk) begin
    if (mvalid) begin
      chk("pc", int'(pc), m_pc);
      chk("pc_prev", int'(pc_prev), m_prev);
      chk("ras_full", int'(ras_full), int'(RAS && stk.size() == DEPTH));
      chk("ras_empty", int'(ras_empty), int'(stk.size() == 0));
      chk("ras_ovf", int'(ras_ovf), m_ovf);
      chk("ras_unf", int'(ras_unf), m_unf);
      chk("ps_illegal", int'(ps_illegal), m_ill);
    end
  end

  initial begin
    int p, r;
    // reset then three increments
    step(1, 0, 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_empty", int'(ras_empty), 1);
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("inc3_pc", int'(pc), 3);
    chk("inc3_prev", int'(pc_prev), 2);
    // branches
    step(0, 0, 3, 10);
    step(0, 0, 2, 0, 6'b111101);
    chk("br_neg", int'(pc), 8);
    step(0, 0, 2, 0, 5);
    chk("br_pos", int'(pc), 14);
    // wrap-around
    step(0, 0, 3, 63); step(0, 0, 1);
    chk("wrap_inc", int'(pc), 0);
    step(0, 0, 3, 62); step(0, 0, 2, 0, 4);
    chk("wrap_br", int'(pc), 3);
    // call / return
    step(1, 0, 0);
    step(0, 0, 3, 4);
    step(0, 0, 4, 20);
    chk("call_pc", int'(pc), 20);
    chk("call_empty", int'(ras_empty), RAS ? 0 : 1);
    step(0, 0, 1);
    chk("call_inc", int'(pc), 21);
    step(0, 0, 5);
    chk("ret_pc", int'(pc), RAS ? 5 : 22);
    chk("ret_empty", int'(ras_empty), 1);
    // overflow and underflow
    step(1, 0, 0);
    step(0, 0, 4, 10); step(0, 0, 4, 20); step(0, 0, 4, 30);
    step(0, 0, 4, 40); step(0, 0, 4, 50);
    chk("ovf_flag", int'(ras_ovf), RAS ? 1 : 0);
    chk("ovf_full", int'(ras_full), RAS ? 1 : 0);
    step(0, 0, 5); chk("lifo0", int'(pc), RAS ? 41 : 51);
    step(0, 0, 5); chk("lifo1", int'(pc), RAS ? 31 : 52);
    step(0, 0, 5); chk("lifo2", int'(pc), RAS ? 21 : 53);
    step(0, 0, 5); chk("lifo3", int'(pc), RAS ? 11 : 54);
    step(0, 0, 5);
    chk("unf_pc", int'(pc), RAS ? 12 : 55);
    chk("unf_flag", int'(ras_unf), 1);
    // stall, reserved, reset during stall
    step(0, 1, 4, 33);
    chk("stall_pc", int'(pc), RAS ? 12 : 55);
    step(0, 0, 6);
    chk("rsv_pc", int'(pc), RAS ? 12 : 55);
    chk("rsv_ill", int'(ps_illegal), 1);
    step(0, 1, 1);
    chk("stall_ill", int'(ps_illegal), 1);
    step(1, 1, 4, 9);
    chk("rst_stall_pc", int'(pc), 0);
    chk("rst_stall_unf", int'(ras_unf), 0);
    chk("rst_stall_ill", int'(ps_illegal), 0);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      p = (r < 75) ? $urandom_range(1, 5) : $urandom_range(0, 7);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, p,
           $urandom_range(0, MASK), $urandom_range(0, (1 << OFS_W) - 1));
    end
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
